sensor_monitor: RTL and testbench

SENSOR_MONITOR -- requirements
Module: sensor_monitor

---
 rtl/sensor_monitor_if.sv | 48 ++++
 rtl/sensor_monitor.sv | 167 ++++++++++++++++
 tb/tb_sensor_monitor.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : sensor_monitor_if
// Brief    : Sample, threshold-config, readback and alarm bundle for sensor_monitor
// Revision : 1.0
// ============================================================================
interface sensor_monitor_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
);
  logic                sample_valid;
  logic [3:0]          sample_ch;
  logic [WIDTH-1:0]    sample_data;

  logic                cfg_wr_en;
  logic [3:0]          cfg_ch;
  logic                cfg_sel;
  logic [WIDTH-1:0]    cfg_wdata;

  logic                rd_en;
  logic [3:0]          rd_ch;
  logic [1:0]          rd_sel;
  logic [WIDTH-1:0]    rd_data;
  logic                rd_valid;

  logic [CHANNELS-1:0] alarm_clr;
  logic                minmax_clr;
  logic [CHANNELS-1:0] alarm_live;
  logic [CHANNELS-1:0] alarm_sticky;
  logic                irq;

  modport master (
    output sample_valid, sample_ch, sample_data,
    output cfg_wr_en, cfg_ch, cfg_sel, cfg_wdata,
    output rd_en, rd_ch, rd_sel,
    output alarm_clr, minmax_clr,
    input  rd_data, rd_valid, alarm_live, alarm_sticky, irq
  );

  modport slave (
    input  sample_valid, sample_ch, sample_data,
    input  cfg_wr_en, cfg_ch, cfg_sel, cfg_wdata,
    input  rd_en, rd_ch, rd_sel,
    input  alarm_clr, minmax_clr,
    output rd_data, rd_valid, alarm_live, alarm_sticky, irq
  );
endinterface
`default_nettype wire

// File: rtl/sensor_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sensor_monitor
// Brief    : Multi-channel threshold monitor with debounce, hysteresis, min/max
// Revision : 1.0
// ============================================================================
module sensor_monitor #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int DEBOUNCE = 3,
  parameter int HYST     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  sensor_monitor_if.slave  bus
);

  typedef logic [WIDTH-1:0] word_t;

  localparam logic [3:0]   C_DEB  = 4'(DEBOUNCE);
  localparam logic [WIDTH:0] C_HYST = (WIDTH+1)'(HYST);
  localparam word_t        C_ONES = {WIDTH{1'b1}};

  word_t               last_q [CHANNELS];
  word_t               last_d [CHANNELS];
  word_t               min_q  [CHANNELS];
  word_t               min_d  [CHANNELS];
  word_t               max_q  [CHANNELS];
  word_t               max_d  [CHANNELS];
  word_t               lo_q   [CHANNELS];
  word_t               lo_d   [CHANNELS];
  word_t               hi_q   [CHANNELS];
  word_t               hi_d   [CHANNELS];
  logic [3:0]          cnt_q  [CHANNELS];
  logic [3:0]          cnt_d  [CHANNELS];
  logic [CHANNELS-1:0] seen_q, seen_d;
  logic [CHANNELS-1:0] live_q, live_d;
  logic [CHANNELS-1:0] sticky_q, sticky_d;
  logic                irq_q, irq_d;
  logic                rd_valid_q, rd_valid_d;
  word_t               rd_data_q, rd_data_d;

  logic [WIDTH:0]      w_lo_sum [CHANNELS];
  word_t               w_lo_h   [CHANNELS];
  word_t               w_hi_h   [CHANNELS];
  logic [CHANNELS-1:0] w_hit, w_oor, w_band, w_reach;
  word_t               w_rd_word;

  // Alarm-clear band edges, saturated so the band never wraps around.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_lo_sum[c] = {1'b0, lo_q[c]} + C_HYST;
      w_lo_h[c]   = w_lo_sum[c][WIDTH] ? C_ONES : w_lo_sum[c][WIDTH-1:0];
      w_hi_h[c]   = ({1'b0, hi_q[c]} < C_HYST) ? '0 : (hi_q[c] - C_HYST[WIDTH-1:0]);
    end
  end

  always_comb begin
    last_d   = last_q;
    min_d    = min_q;
    max_d    = max_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    seen_d   = seen_q;
    live_d   = live_q;
    sticky_d = sticky_q;
    w_hit    = '0;
    w_oor    = '0;
    w_band   = '0;
    w_reach  = '0;

    for (int c = 0; c < CHANNELS; c++) begin
      w_hit[c]   = bus.sample_valid && (bus.sample_ch == 4'(c));
      w_oor[c]   = (bus.sample_data < lo_q[c]) || (bus.sample_data > hi_q[c]);
      w_band[c]  = (bus.sample_data >= w_lo_h[c]) && (bus.sample_data <= w_hi_h[c]);
      w_reach[c] = w_oor[c] && ((cnt_q[c] + 4'd1) == C_DEB);

      if (w_hit[c]) begin
        last_d[c] = bus.sample_data;
        seen_d[c] = 1'b1;
        if (!seen_q[c] || bus.minmax_clr) begin
          min_d[c] = bus.sample_data;
          max_d[c] = bus.sample_data;
        end else begin
          if (bus.sample_data < min_q[c]) min_d[c] = bus.sample_data;
          if (bus.sample_data > max_q[c]) max_d[c] = bus.sample_data;
        end
        if (w_oor[c])
          cnt_d[c] = (cnt_q[c] == C_DEB) ? cnt_q[c] : cnt_q[c] + 4'd1;
        else
          cnt_d[c] = 4'd0;
        if (w_reach[c])
          live_d[c] = 1'b1;
        else if (w_band[c])
          live_d[c] = 1'b0;
      end else if (bus.minmax_clr) begin
        seen_d[c] = 1'b0;
      end

      // Thresholds written this cycle only affect later samples.
      if (bus.cfg_wr_en && (bus.cfg_ch == 4'(c))) begin
        if (bus.cfg_sel) hi_d[c] = bus.cfg_wdata;
        else             lo_d[c] = bus.cfg_wdata;
      end

      sticky_d[c] = (sticky_q[c] & ~bus.alarm_clr[c]) | (live_d[c] & ~live_q[c]);
    end
  end

  always_comb begin
    w_rd_word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.rd_ch == 4'(c)) begin
        case (bus.rd_sel)
          2'd0:    w_rd_word = last_q[c];
          2'd1:    w_rd_word = min_q[c];
          2'd2:    w_rd_word = max_q[c];
          default: w_rd_word = word_t'({seen_q[c], sticky_q[c], live_q[c], cnt_q[c]});
        endcase
      end
    end
    rd_valid_d = bus.rd_en;
    rd_data_d  = bus.rd_en ? w_rd_word : rd_data_q;
    irq_d      = |sticky_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        last_q[c] <= '0;
        min_q[c]  <= '0;
        max_q[c]  <= '0;
        lo_q[c]   <= '0;
        hi_q[c]   <= C_ONES;
        cnt_q[c]  <= 4'd0;
      end
      seen_q     <= '0;
      live_q     <= '0;
      sticky_q   <= '0;
      irq_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      last_q     <= last_d;
      min_q      <= min_d;
      max_q      <= max_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      live_q     <= live_d;
      sticky_q   <= sticky_d;
      irq_q      <= irq_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.alarm_live   = live_q;
  assign bus.alarm_sticky = sticky_q;
  assign bus.irq          = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_monitor
// Brief    : Directed scoreboard bench for sensor_monitor
// Revision : 1.0
// ============================================================================
module tb_sensor_monitor;

  localparam int CH = 4;
  localparam int W  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sensor_monitor_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  sensor_monitor #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .DEBOUNCE (3),
    .HYST     (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [W-1:0] exp_q[$];
  string       tag_q[$];
  logic [W-1:0] mon_e;
  string       mon_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bus.cfg_wr_en    = 1'b0;
    bus.rd_en        = 1'b0;
    bus.alarm_clr    = '0;
    bus.minmax_clr   = 1'b0;
  endtask

  task automatic s(input int ch, input int d);
    bus.sample_valid = 1'b1;
    bus.sample_ch    = 4'(ch);
    bus.sample_data  = 16'(d);
  endtask

  task automatic c(input int ch, input int sel, input int d);
    bus.cfg_wr_en = 1'b1;
    bus.cfg_ch    = 4'(ch);
    bus.cfg_sel   = 1'(sel);
    bus.cfg_wdata = 16'(d);
  endtask

  task automatic r(input int ch, input int sel, input int e, input string nm);
    bus.rd_en  = 1'b1;
    bus.rd_ch  = 4'(ch);
    bus.rd_sel = 2'(sel);
    exp_q.push_back(16'(e));
    tag_q.push_back(nm);
  endtask

  // Readback monitor: every rd_valid pulse consumes one expected word.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.rd_valid === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rd_valid: got rd_data %0h, required no readback", bus.rd_data);
        end else begin
          mon_e = exp_q.pop_front();
          mon_t = tag_q.pop_front();
          if (bus.rd_data !== mon_e) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", mon_t, bus.rd_data, mon_e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200us");
    $fatal(1);
  end

  initial begin
    bus.sample_valid = 1'b0; bus.sample_ch = '0; bus.sample_data = '0;
    bus.cfg_wr_en = 1'b0; bus.cfg_ch = '0; bus.cfg_sel = 1'b0; bus.cfg_wdata = '0;
    bus.rd_en = 1'b0; bus.rd_ch = '0; bus.rd_sel = '0;
    bus.alarm_clr = '0; bus.minmax_clr = 1'b0;
    #1 rst_n = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_live", int'(bus.alarm_live), 0);
    chk("rst_sticky", int'(bus.alarm_sticky), 0);
    chk("rst_irq", int'(bus.irq), 0);
    chk("rst_rd_valid", int'(bus.rd_valid), 0);
    chk("rst_rd_data", int'(bus.rd_data), 0);
    tick(); r(0, 0, 0, "rst_last0");
    tick(); r(0, 3, 0, "rst_status0");
    tick(); r(1, 2, 0, "rst_max1");

    // Min/max/last tracking and minmax_clr
    tick(); s(0, 500);
    tick(); s(0, 200);
    tick(); s(0, 800);
    tick(); r(0, 1, 200, "min0");
    tick(); r(0, 2, 800, "max0");
    tick(); r(0, 0, 800, "last0");
    tick(); r(0, 3, 16'h0040, "status0_seen");
    tick(); bus.minmax_clr = 1'b1; s(0, 300);
    tick(); r(0, 1, 300, "min0_clr_same");
    tick(); r(0, 2, 300, "max0_clr_same");
    tick(); bus.minmax_clr = 1'b1;
    tick(); r(0, 3, 0, "status0_unseen");
    tick(); s(0, 100);
    tick(); r(0, 1, 100, "min0_reload");
    tick(); r(0, 2, 100, "max0_reload");

    // Debounce to alarm on ch1
    tick(); c(1, 1, 1000);
    tick(); s(1, 1001);
    tick(); s(1, 1001);
    tick(); chk("live_before_deb", int'(bus.alarm_live), 0); r(1, 3, 16'h0042, "status1_cnt2");
    tick(); s(1, 1001);
    tick();
    chk("live1_set", int'(bus.alarm_live), 4'b0010);
    chk("sticky1_set", int'(bus.alarm_sticky), 4'b0010);
    chk("irq_lag", int'(bus.irq), 0);
    tick(); chk("irq_set", int'(bus.irq), 1); r(1, 3, 16'h0073, "status1_alarm");

    // Hysteresis release and sticky clear
    tick(); s(1, 990);
    tick(); chk("live1_hyst_hold", int'(bus.alarm_live), 4'b0010); r(1, 3, 16'h0070, "status1_hold");
    tick(); s(1, 984);
    tick();
    chk("live1_released", int'(bus.alarm_live), 0);
    chk("sticky1_kept", int'(bus.alarm_sticky), 4'b0010);
    r(1, 3, 16'h0060, "status1_released");
    tick(); bus.alarm_clr = 4'b0010;
    tick(); chk("sticky1_cleared", int'(bus.alarm_sticky), 0);
    tick(); chk("irq_cleared", int'(bus.irq), 0);

    // Out-of-range channel index
    tick(); s(7, 16'h1234); c(7, 0, 16'h0500);
    tick(); r(3, 0, 0, "last3_untouched");
    tick(); r(3, 3, 0, "status3_untouched");
    tick(); r(7, 0, 0, "rd_ch7_last");
    tick(); r(7, 3, 0, "rd_ch7_status");

    // Strict threshold edges, read-during-update, clear/set collision
    tick(); c(2, 0, 100);
    tick(); c(2, 1, 200);
    tick(); s(2, 100);
    tick(); s(2, 99);
    tick(); s(2, 201); r(2, 3, 16'h0041, "status2_pre_201");
    tick(); s(2, 200); r(2, 3, 16'h0042, "status2_pre_200");
    tick(); r(2, 3, 16'h0040, "status2_inrange");
    tick(); s(2, 50);
    tick(); s(2, 50);
    tick(); s(2, 50); bus.alarm_clr = 4'b0100;
    tick();
    chk("live2_set", int'(bus.alarm_live), 4'b0100);
    chk("sticky2_set_wins", int'(bus.alarm_sticky), 4'b0100);
    tick(); chk("irq2_set", int'(bus.irq), 1); r(2, 3, 16'h0073, "status2_alarm");

    // Same-cycle cfg write uses old threshold
    tick(); s(3, 20); c(3, 1, 10);
    tick(); r(3, 3, 16'h0040, "status3_old_hi");
    tick(); s(3, 20);
    tick(); r(3, 3, 16'h0041, "status3_new_hi");
    tick(); s(3, 20);
    tick(); r(3, 3, 16'h0042, "status3_cnt2");

    // Readback same cycle as sample returns pre-update value
    tick(); s(0, 7); r(0, 0, 100, "last0_pre_update");
    tick(); r(0, 0, 7, "last0_post_update");
    tick(); r(0, 1, 7, "min0_new");

    // Asynchronous reset mid-debounce and mid-readback
    tick(); chk("irq_before_rst", int'(bus.irq), 1);
    bus.rd_en = 1'b1; bus.rd_ch = 4'd0; bus.rd_sel = 2'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_live", int'(bus.alarm_live), 0);
    chk("async_sticky", int'(bus.alarm_sticky), 0);
    chk("async_irq", int'(bus.irq), 0);
    chk("async_rd_valid", int'(bus.rd_valid), 0);
    chk("async_rd_data", int'(bus.rd_data), 0);
    tick(); s(1, 9);
    tick(); s(1, 9);
    tick(); rst_n = 1'b1; s(0, 55);
    tick(); chk("no_rd_valid_after_rst", int'(bus.rd_valid), 0); r(0, 0, 55, "first_accept_last0");
    tick(); r(3, 3, 0, "status3_after_rst");
    tick(); r(1, 0, 0, "last1_ignored_in_rst");
    tick(); r(0, 1, 55, "min0_after_rst");

    tick(); tick(); tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
